qpsk_stream_demapper: RTL and testbench
=======================================

Name: qpsk_stream_demapper

Overview:
- Streaming, parametrised QPSK hard-decision demapper.
- Accepts one complex symbol per cycle over a valid/ready handshake and assembles DATA_BITS-wide words, 2 bits per symbol, MSB first.
- Presents each completed word on a registered valid/ready output.
- Sits between the receive equaliser/symbol sampler and the frame/character decoder; replaces the fixed 4-symbol combinational demodulator.

Parameters:
- SYM_W, 16: width of each signed two's-complement I/Q sample.
- DATA_BITS, 7: output word width, range 2..32. SYMS = ceil(DATA_BITS/2) symbols per word.
- ERASE_THR, 256: magnitude threshold for erasure flagging (used only with QPSK_ERASURE_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_re  in  SYM_W  symbol real part, signed.
- in_im  in  SYM_W  symbol imaginary part, signed.
- in_sop  in  1  marks the first symbol of a new word; forces realignment.
- in_valid  in  1  symbol present.
- in_ready  out  1  block can accept a symbol this cycle.
- out_data  out  DATA_BITS  demapped word.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts the word.
- drop_cnt  out  8  saturating count of partial words discarded by in_sop.
- out_erase  out  1  low-confidence flag for the word (QPSK_ERASURE_EN only; otherwise tied 0).

Behaviour:
- Reset: synchronous, sampled on the rising edge when rst_n=0. Clears sym_idx=0, shift register=0, out_data=0, out_valid=0, drop_cnt=0, out_erase=0, state=COLLECT. Reset mid-word discards the partial word and does not increment drop_cnt.
- Accept: a symbol is accepted when in_valid && in_ready.
- in_ready = !(out_valid && !out_ready), i.e. stall only while a finished word is held unconsumed. Combinational from out_valid/out_ready only, never from in_valid.
- Mapping per symbol: bit pair = {im sign, re sign}, sign = sample[SYM_W-1]. This gives (re>=0,im>=0)->00, (re<0,im>=0)->01, (re>=0,im<0)->10, (re<0,im<0)->11. Zero counts as non-negative.
- Packing: symbol k (k=0..SYMS-1) fills bits [DATA_BITS-1-2k : DATA_BITS-2-2k]. If DATA_BITS is odd, the last symbol supplies only its im-sign bit, into bit 0; its re sign is ignored.
- State COLLECT: sym_idx counts 0..SYMS-1 on each accept. When the symbol at sym_idx=SYMS-1 is accepted, on the next edge: out_data <= assembled word, out_valid <= 1, sym_idx <= 0, state FULL.
- State FULL: out_valid=1. Collection of the next word continues while in_ready=1.
  - On out_ready: out_valid clears the next cycle unless a new word completes that same cycle. In that case out_valid stays 1 and out_data takes the new word; no bubble.
- Latency: out_valid rises 1 cycle after the final symbol is accepted. Sustained throughput is 1 symbol/cycle when out_ready=1.
- out_data and out_erase are stable while out_valid && !out_ready.
- in_sop accepted with sym_idx!=0: discard the partial word, increment drop_cnt (saturating at 255), and treat this symbol as k=0. in_sop with sym_idx=0 has no effect beyond normal acceptance.
- in_valid while in_ready=0: ignored; the source must hold its data.

Optional Feature:
- Macro QPSK_ERASURE_EN.
- Defined:
  - For each contributing component, |x| = x<0 ? -x : x, computed at SYM_W+1 bits so the most-negative value maps to 2^(SYM_W-1).
  - Word erasure = OR over all symbols of (|re|<ERASE_THR || |im|<ERASE_THR). For odd DATA_BITS, only |im| of the last symbol is checked.
  - out_erase is registered with out_data, has the same timing, and is cleared per word.
- Undefined: no magnitude logic is built and out_erase is constant 0.

Test Plan:
- Defaults, out_ready=1; symbols (+100,+100),(-100,+100),(+100,-100),(-5,-5) back-to-back -> out_data=7'b0001101 one cycle after the 4th accept, out_valid high for 1 cycle.
- Backpressure: out_ready=0 with two full words streamed -> in_ready drops after word 1 completes, word 1 held stable, no symbol lost; release out_ready -> word 2 follows with correct bits.
- Resync: 2 symbols accepted, then in_sop with 4 new symbols (all re<0, im<0) -> drop_cnt=1, out_data=7'b1111111. Repeat 300 times -> drop_cnt saturates at 255.
- DATA_BITS=8, SYM_W=12: four symbols (-1,0),(0,-1),(0,0),(-2048,-2048) -> out_data=8'b01100011.
- QPSK_ERASURE_EN, ERASE_THR=256: word whose 3rd symbol re=+200 -> out_erase=1. Same word with re=+300 -> 0. Odd last symbol re=+1, im=-1000 -> out_erase=0.
- Reset pulse (rst_n=0 one cycle) mid-word and while out_valid=1 -> next edge: out_valid=0, drop_cnt=0; the next 4 symbols form a fresh word.

Source files
------------

// File: rtl/qpsk_stream_demapper_if.sv
// Symbol-in / word-out stream bundle for qpsk_stream_demapper.
// The master side is the symbol source plus word sink; the demapper sits on the slave side.
interface qpsk_stream_demapper_if #(
   parameter int SYM_W     = 16,
   parameter int DATA_BITS = 7
);
   logic signed [SYM_W-1:0] in_re;
   logic signed [SYM_W-1:0] in_im;
   logic                    in_sop;
   logic                    in_valid;
   logic                    in_ready;
   logic [DATA_BITS-1:0]    out_data;
   logic                    out_valid;
   logic                    out_ready;
   logic                    out_erase;

   modport master (
      output in_re, in_im, in_sop, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_erase
   );

   modport slave (
      input  in_re, in_im, in_sop, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_erase
   );
endinterface

// File: rtl/qpsk_stream_demapper.sv
// Streaming QPSK hard-decision demapper: packs 2 sign bits per symbol, MSB first, into DATA_BITS words.
// Optional macro QPSK_ERASURE_EN adds a per-word low-magnitude erasure flag on out_erase.
module qpsk_stream_demapper #(
   parameter int SYM_W     = 16,
   parameter int DATA_BITS = 7,
   parameter int ERASE_THR = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   qpsk_stream_demapper_if.slave bus,
   output logic [7:0]            drop_cnt
);

   localparam int SYMS   = (DATA_BITS + 1) / 2;
   localparam int WORD_W = 2 * SYMS;
   localparam int IDX_W  = (SYMS > 1) ? $clog2(SYMS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SYMS - 1);

   typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

   state_t            state_reg;
   state_t            state_next;
   logic [IDX_W-1:0]  sym_idx_reg;
   logic [IDX_W-1:0]  sym_idx_next;
   logic [IDX_W-1:0]  eff_idx;
   logic [WORD_W-1:0] shift_reg;
   logic [WORD_W-1:0] shift_next;
   logic [DATA_BITS-1:0] out_data_reg;
   logic [7:0]        drop_cnt_reg;
   logic              out_valid;
   logic              in_ready;
   logic              accept;
   logic              realign;
   logic              word_done;
   logic [1:0]        sym_bits;

   // Input stalls only while a finished word waits for the sink.
   assign in_ready  = !(out_valid && !bus.out_ready);
   assign accept    = bus.in_valid && in_ready;
   assign realign   = accept && bus.in_sop && (sym_idx_reg != '0);
   assign eff_idx   = bus.in_sop ? '0 : sym_idx_reg;
   assign word_done = accept && (eff_idx == LAST_IDX);
   assign sym_bits  = {bus.in_im[SYM_W-1], bus.in_re[SYM_W-1]};

   // Each symbol slot owns one bit pair; a resync clears the stale partial word.
   for (genvar gi = 0; gi < SYMS; gi++) begin : g_slot
      localparam int HI = WORD_W - 1 - 2 * gi;
      assign shift_next[HI -: 2] = (accept && (eff_idx == IDX_W'(gi))) ? sym_bits :
                                   (accept && bus.in_sop)               ? 2'b00    :
                                                                          shift_reg[HI -: 2];
   end

   always_comb begin
      sym_idx_next = sym_idx_reg;
      if (accept) begin
         if (word_done) begin
            sym_idx_next = '0;
         end else begin
            sym_idx_next = eff_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= COLLECT;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         COLLECT: begin
            if (word_done) begin
               state_next = FULL;
            end
         end
         FULL: begin
            if (word_done) begin
               state_next = FULL;
            end else if (bus.out_ready) begin
               state_next = COLLECT;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   always_comb begin
      out_valid = 1'b0;
      if (state_reg == FULL) begin
         out_valid = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sym_idx_reg  <= '0;
         shift_reg    <= '0;
         out_data_reg <= '0;
         drop_cnt_reg <= '0;
      end else begin
         sym_idx_reg <= sym_idx_next;
         shift_reg   <= shift_next;
         if (word_done) begin
            out_data_reg <= shift_next[WORD_W-1 -: DATA_BITS];
         end
         if (realign && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = out_data_reg;
   assign drop_cnt      = drop_cnt_reg;

`ifdef QPSK_ERASURE_EN
   localparam bit ODD_BITS = (DATA_BITS % 2) != 0;
   localparam logic [SYM_W:0] THR = (SYM_W + 1)'(ERASE_THR);

   logic signed [SYM_W:0] re_ext;
   logic signed [SYM_W:0] im_ext;
   logic [SYM_W:0]        re_mag;
   logic [SYM_W:0]        im_mag;
   logic                  last_odd;
   logic                  sym_low;
   logic                  erase_acc_reg;
   logic                  erase_acc_next;
   logic                  out_erase_reg;

   // One extra bit keeps the most-negative sample's magnitude representable.
   assign re_ext   = {bus.in_re[SYM_W-1], bus.in_re};
   assign im_ext   = {bus.in_im[SYM_W-1], bus.in_im};
   assign re_mag   = re_ext[SYM_W] ? $unsigned(-re_ext) : $unsigned(re_ext);
   assign im_mag   = im_ext[SYM_W] ? $unsigned(-im_ext) : $unsigned(im_ext);
   assign last_odd = ODD_BITS && (eff_idx == LAST_IDX);
   assign sym_low  = (im_mag < THR) || ((re_mag < THR) && !last_odd);

   always_comb begin
      erase_acc_next = erase_acc_reg;
      if (accept) begin
         erase_acc_next = ((eff_idx == '0) ? 1'b0 : erase_acc_reg) | sym_low;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         erase_acc_reg <= 1'b0;
         out_erase_reg <= 1'b0;
      end else begin
         erase_acc_reg <= erase_acc_next;
         if (word_done) begin
            out_erase_reg <= erase_acc_next;
         end
      end
   end

   assign bus.out_erase = out_erase_reg;
`else
   logic unused_cfg;
   assign unused_cfg    = ^{bus.in_re[SYM_W-2:0], bus.in_im[SYM_W-2:0], ERASE_THR};
   assign bus.out_erase = 1'b0;
`endif

endmodule

// File: tb/tb_qpsk_stream_demapper.sv
// Self-checking bench for qpsk_stream_demapper: directed literal cases plus randomized
// traffic compared every cycle against a queue/arithmetic model of the stream.
module tb_qpsk_stream_demapper;
   localparam int SYM_W     = 16;
   localparam int DATA_BITS = 7;
   localparam int SYMS      = 4;
   localparam int ERASE_THR = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [7:0] drop_cnt;
   always #5 clk = ~clk;

   qpsk_stream_demapper_if #(.SYM_W(SYM_W), .DATA_BITS(DATA_BITS)) bus();

   qpsk_stream_demapper #(.SYM_W(SYM_W), .DATA_BITS(DATA_BITS), .ERASE_THR(ERASE_THR)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .drop_cnt (drop_cnt)
   );

   int tests = 0;
   int fails = 0;
   int ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
   int words_seen = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic int absv(input int x);
      return (x < 0) ? -x : x;
   endfunction

   // ---------------- reference model ----------------
   logic                 m_valid = 1'b0;
   logic [DATA_BITS-1:0] m_data = '0;
   logic                 m_erase = 1'b0;
   int                   m_drop = 0;
   int                   m_n = 0;
   int                   sre [SYMS];
   int                   sim [SYMS];
   bit                   live = 1'b0;

   always @(negedge clk) begin : model_blk
      logic                 exp_ready;
      logic [DATA_BITS-1:0] w;
      logic                 er;
      int                   hi;
      exp_ready = !(m_valid && !bus.out_ready);
      if (live) begin
         chk("in_ready", bus.in_ready, exp_ready);
         chk("out_valid", bus.out_valid, m_valid);
         chk("out_data", bus.out_data, m_data);
         chk("out_erase", bus.out_erase, m_erase);
         chk("drop_cnt", drop_cnt, m_drop);
      end
      if (!rst_n) begin
         m_valid = 1'b0;
         m_data  = '0;
         m_erase = 1'b0;
         m_drop  = 0;
         m_n     = 0;
         live    = 1'b1;
      end else if (live) begin
         if (m_valid && bus.out_ready) m_valid = 1'b0;
         if (bus.in_valid && exp_ready) begin
            if (bus.in_sop && m_n != 0) begin
               if (m_drop < 255) m_drop++;
               m_n = 0;
            end
            sre[m_n] = bus.in_re;
            sim[m_n] = bus.in_im;
            m_n++;
            if (m_n == SYMS) begin
               w  = '0;
               er = 1'b0;
               for (int k = 0; k < SYMS; k++) begin
                  hi = DATA_BITS - 1 - 2 * k;
                  w[hi] = (sim[k] < 0);
                  if (absv(sim[k]) < ERASE_THR) er = 1'b1;
                  if (hi >= 1) begin
                     w[hi-1] = (sre[k] < 0);
                     if (absv(sre[k]) < ERASE_THR) er = 1'b1;
                  end
               end
               m_data = w;
`ifdef QPSK_ERASURE_EN
               m_erase = er;
`else
               m_erase = 1'b0;
`endif
               m_valid = 1'b1;
               m_n = 0;
               words_seen++;
               $display("[TB] word %0d data=%b erase=%0d drop=%0d", words_seen, w, m_erase, m_drop);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.out_ready = 1'b1;
            2:       bus.out_ready = 1'b0;
            default: bus.out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at posedge+1; returns at posedge+1 just after the symbol was taken.
   task automatic send(input int re, input int im, input bit sop);
      int  n;
      bit  took;
      n = 0;
      took = 1'b0;
      bus.in_re    = 16'(re);
      bus.in_im    = 16'(im);
      bus.in_sop   = sop;
      bus.in_valid = 1'b1;
      while (!took && n < 1000) begin
         @(negedge clk);
         took = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!took) chk("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
   endtask

   task automatic word_check(input string name, input int r0, input int i0, input int r1, input int i1,
                             input int r2, input int i2, input int r3, input int i3,
                             input logic [DATA_BITS-1:0] exp_data, input logic exp_erase);
      send(r0, i0, 1'b1);
      send(r1, i1, 1'b0);
      send(r2, i2, 1'b0);
      send(r3, i3, 1'b0);
      @(negedge clk);
      chk({name, "_valid"}, bus.out_valid, 1'b1);
      chk({name, "_data"}, bus.out_data, exp_data);
`ifdef QPSK_ERASURE_EN
      chk({name, "_erase"}, bus.out_erase, exp_erase);
`else
      chk({name, "_erase"}, bus.out_erase, 1'b0 & exp_erase);
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset(input string name);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk({name, "_valid"}, bus.out_valid, 1'b0);
      chk({name, "_drop"}, drop_cnt, 8'd0);
      @(posedge clk);
      #1;
   endtask

   function automatic int rnd();
      case ($urandom_range(0, 4))
         0:       return 0;
         1:       return -32768;
         2:       return int'($urandom_range(0, 600)) - 300;
         default: return int'($urandom_range(0, 65535)) - 32768;
      endcase
   endfunction

   initial begin
      bus.in_valid = 1'b0;
      bus.in_sop   = 1'b0;
      bus.in_re    = '0;
      bus.in_im    = '0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);

      // Basic word, one-cycle valid pulse with out_ready=1
      word_check("basic", 100, 100, -100, 100, 100, -100, -5, -5, 7'b0001101, 1'b1);
      @(negedge clk);
      chk("basic_valid_drop", bus.out_valid, 1'b0);
      @(posedge clk);
      #1;

      // Backpressure: word 1 held, word 2 follows after release
      ready_mode = 2;
      idle(2);
      fork
         begin
            for (int k = 0; k < 4; k++) send(100, -100, k == 0);
            for (int k = 0; k < 4; k++) send(-100, 100, k == 0);
         end
         begin
            repeat (10) @(posedge clk);
            @(negedge clk);
            chk("bp_hold_valid", bus.out_valid, 1'b1);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_hold_data", bus.out_data, 7'b1010101);
            ready_mode = 0;
         end
      join
      @(negedge clk);
      chk("bp_word2_valid", bus.out_valid, 1'b1);
      chk("bp_word2_data", bus.out_data, 7'b0101010);
      @(posedge clk);
      #1;
      idle(2);

      // Resync with drop counting and saturation
      pulse_reset("rst_pre");
      for (int it = 0; it < 300; it++) begin
         send(50, 50, 1'b0);
         send(60, -60, 1'b0);
         for (int k = 0; k < 4; k++) send(-7, -9, k == 0);
         if (it == 0) begin
            @(negedge clk);
            chk("rs_data", bus.out_data, 7'b1111111);
            chk("rs_drop1", drop_cnt, 8'd1);
            @(posedge clk);
            #1;
         end
      end
      idle(1);
      chk("rs_drop_sat", drop_cnt, 8'd255);

      // Reset mid-word, then reset while a word is held
      send(500, 500, 1'b0);
      send(-500, 500, 1'b0);
      pulse_reset("rst_mid");
      ready_mode = 2;
      idle(2);
      for (int k = 0; k < 4; k++) send(-300, -300, k == 0);
      idle(1);
      pulse_reset("rst_full");
      ready_mode = 0;
      idle(2);
      word_check("fresh", 1000, 1000, 1000, 1000, -1000, -1000, 1000, -1000, 7'b0000111, 1'b0);

      // Erasure thresholds (out_erase stays 0 without the feature)
      word_check("er_low", 1000, 1000, 1000, -1000, 200, 1000, -1000, -1000, 7'b0010001, 1'b1);
      word_check("er_high", 1000, 1000, 1000, -1000, 300, 1000, -1000, -1000, 7'b0010001, 1'b0);
      word_check("er_oddre", 1000, 1000, 1000, 1000, 1000, 1000, 1, -1000, 7'b0000001, 1'b0);

      // Randomized traffic against the model
      ready_mode = 1;
      for (int it = 0; it < 2000; it++) begin
         if ($urandom_range(0, 3) == 0) idle(1 + $urandom_range(0, 2));
         send(rnd(), rnd(), $urandom_range(0, 7) == 0);
      end
      ready_mode = 0;
      idle(10);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
